modexp_ctrl: RTL

Modular-exponentiation controller for the RSA datapath. It computes `result = base^exponent mod modulus` by right-to-left square-and-multiply. It acts as the initiator of the existing `ld`/`Done` reduction handshake: it forms each double-width product internally and issues it to an external 64-bit modulo responder for reduction. It sits between the key/message registers and the modulo unit, and the top level wires the two together.

---
 rtl/rsa_pkg.sv | 23 ++
 rtl/mul_unit.sv | 15 +
 rtl/modexp_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared widths, controller state encoding and a small state helper for the
// modular-exponentiation datapath.
package rsa_pkg;

  localparam int WIDTH  = 32;
  localparam int PWIDTH = 2 * WIDTH;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RED_REQ  = 4'd1;
  localparam logic [3:0] S_RED_WAIT = 4'd2;
  localparam logic [3:0] S_STEP     = 4'd3;
  localparam logic [3:0] S_MUL_REQ  = 4'd4;
  localparam logic [3:0] S_MUL_WAIT = 4'd5;
  localparam logic [3:0] S_SQR_REQ  = 4'd6;
  localparam logic [3:0] S_SQR_WAIT = 4'd7;
  localparam logic [3:0] S_FIN      = 4'd8;

  // True for the states that issue a reduction request to the responder.
  function automatic logic is_req(input logic [3:0] s);
    return (s == S_RED_REQ) || (s == S_MUL_REQ) || (s == S_SQR_REQ);
  endfunction

endpackage

// File: rtl/mul_unit.sv
// Full-width unsigned WIDTH x WIDTH -> 2*WIDTH combinational multiplier.
module mul_unit
  import rsa_pkg::*;
#(
  parameter int WIDTH = rsa_pkg::WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  // Both operands widened first so the product is never truncated.
  assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply controller. Every product is reduced by
// an external modulo responder through the ld/done handshake.
module modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = rsa_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   base,
  input  logic [WIDTH-1:0]   exponent,
  input  logic [WIDTH-1:0]   modulus,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               mod_ld,
  output logic [2*WIDTH-1:0] mod_a,
  output logic [2*WIDTH-1:0] mod_b,
  input  logic [2*WIDTH-1:0] mod_o,
  input  logic               mod_done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [3:0]         state, state_n;
  logic [WIDTH-1:0]   r, r_n;
  logic [WIDTH-1:0]   b, b_n;
  logic [WIDTH-1:0]   e, e_n;
  logic [WIDTH-1:0]   mul_x;
  logic [2*WIDTH-1:0] prod;
  logic               accept;
  logic               e_more;
  logic               unused_hi;

  // Remainders are always below the modulus, so the upper half is zero.
  assign unused_hi = ^mod_o[2*WIDTH-1:WIDTH];

  assign accept = (state == S_IDLE) && start;
  assign e_more = (e[WIDTH-1:1] != '0);

  // Multiply needs r*b; square (the only other product) needs b*b.
  assign mul_x = (state_n == S_MUL_REQ) ? r : b;

  mul_unit #(.WIDTH(WIDTH)) u_mul (
    .a (mul_x),
    .b (b),
    .p (prod)
  );

  // Next-state and next-datapath values.
  always_comb begin
    state_n = state;
    r_n     = r;
    b_n     = b;
    e_n     = e;
    case (state)
      S_IDLE: begin
        if (start) begin
          b_n = base;
          e_n = exponent;
          // m<=1 forces a zero result, so the accumulator starts at 0 there.
          r_n     = (modulus > ONE) ? ONE : '0;
          state_n = (modulus > ONE) ? S_RED_REQ : S_FIN;
        end
      end
      S_RED_REQ:  state_n = S_RED_WAIT;
      S_RED_WAIT: begin
        if (mod_done) begin
          b_n     = mod_o[WIDTH-1:0];
          state_n = (e == '0) ? S_FIN : S_STEP;
        end
      end
      S_STEP: begin
        if (e[0])        state_n = S_MUL_REQ;
        else if (e_more) state_n = S_SQR_REQ;
        else             state_n = S_FIN;
      end
      S_MUL_REQ:  state_n = S_MUL_WAIT;
      S_MUL_WAIT: begin
        if (mod_done) begin
          r_n     = mod_o[WIDTH-1:0];
          state_n = e_more ? S_SQR_REQ : S_FIN;
        end
      end
      S_SQR_REQ:  state_n = S_SQR_WAIT;
      S_SQR_WAIT: begin
        if (mod_done) begin
          b_n     = mod_o[WIDTH-1:0];
          e_n     = e >> 1;
          state_n = S_STEP;
        end
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Working registers; they are always reloaded on an accepted start.
  always_ff @(posedge clk) begin
    r <= r_n;
    b <= b_n;
    e <= e_n;
  end

  // Control state and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      mod_ld <= 1'b0;
      mod_a  <= '0;
      mod_b  <= '0;
    end else begin
      state  <= state_n;
      busy   <= (state_n != S_IDLE);
      done   <= (state_n == S_FIN);
      mod_ld <= is_req(state_n);
      if (is_req(state_n)) begin
        mod_a <= (state_n == S_RED_REQ) ? {{WIDTH{1'b0}}, base} : prod;
      end
      if (accept) begin
        mod_b <= {{WIDTH{1'b0}}, modulus};
        err   <= (modulus == '0);
      end
      if (state_n == S_FIN) begin
        result <= r_n;
      end
    end
  end

endmodule
